// File: rtl/wb_arbiter_if.sv
// Writeback bus between the three execution-unit requesters, the issue
// stage and the commit-stage register write port.
interface wb_arbiter_if #(
  parameter int XLEN = 64
);
  logic            io_req0_valid;
  logic [4:0]      io_req0_addr;
  logic [XLEN-1:0] io_req0_data;
  logic            io_req0_ready;

  logic            io_req1_valid;
  logic [4:0]      io_req1_addr;
  logic [XLEN-1:0] io_req1_data;
  logic            io_req1_ready;

  logic            io_req2_valid;
  logic [4:0]      io_req2_addr;
  logic [XLEN-1:0] io_req2_data;
  logic            io_req2_ready;

  logic            io_stall;
  logic            io_issue_valid;
  logic [4:0]      io_issue_rd;

  logic            io_wb_valid;
  logic [4:0]      io_wb_dest_addr;
  logic [XLEN-1:0] io_wb_dest_data;
  logic [31:0]     io_busy;

  // Requesters, issue stage and commit stage side
  modport master (
    output io_req0_valid, io_req0_addr, io_req0_data,
    output io_req1_valid, io_req1_addr, io_req1_data,
    output io_req2_valid, io_req2_addr, io_req2_data,
    output io_stall, io_issue_valid, io_issue_rd,
    input  io_req0_ready, io_req1_ready, io_req2_ready,
    input  io_wb_valid, io_wb_dest_addr, io_wb_dest_data, io_busy
  );

  // Arbiter side
  modport slave (
    input  io_req0_valid, io_req0_addr, io_req0_data,
    input  io_req1_valid, io_req1_addr, io_req1_data,
    input  io_req2_valid, io_req2_addr, io_req2_data,
    input  io_stall, io_issue_valid, io_issue_rd,
    output io_req0_ready, io_req1_ready, io_req2_ready,
    output io_wb_valid, io_wb_dest_addr, io_wb_dest_data, io_busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter for the single GPR write port, with a
// registered write stage and a 32-entry pending-write scoreboard.
// Requester 0 = exu, 1 = lsu, 2 = mdu.
module wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
) (
  input logic         clock,
  input logic         reset,
  wb_arbiter_if.slave bus
);

  // Round-robin pick: search (last+1)%3, (last+2)%3, last; returns one-hot.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [1:0]      last);
    logic [NREQ-1:0] g;
    g = '0;
    case (last)
      2'd0: begin
        if (v[1])      g[1] = 1'b1;
        else if (v[2]) g[2] = 1'b1;
        else if (v[0]) g[0] = 1'b1;
      end
      2'd1: begin
        if (v[2])      g[2] = 1'b1;
        else if (v[0]) g[0] = 1'b1;
        else if (v[1]) g[1] = 1'b1;
      end
      default: begin
        if (v[0])      g[0] = 1'b1;
        else if (v[1]) g[1] = 1'b1;
        else if (v[2]) g[2] = 1'b1;
      end
    endcase
    return g;
  endfunction

  // One-hot grant to index.
  function automatic logic [1:0] grant_idx(input logic [NREQ-1:0] g);
    logic [1:0] idx;
    idx = 2'd0;
    if (g[1]) idx = 2'd1;
    if (g[2]) idx = 2'd2;
    return idx;
  endfunction

  logic [NREQ-1:0] valid;
  logic [NREQ-1:0] grant;
  logic [1:0]      gidx;
  logic            xfer;
  logic [4:0]      gaddr;
  logic [XLEN-1:0] gdata;
  logic [31:0]     clr_mask;
  logic [31:0]     set_mask;
  logic [31:0]     busy_next;

  logic [1:0]      last_p1;
  logic            wb_valid_p1;
  logic [4:0]      wb_addr_p1;
  logic [XLEN-1:0] wb_data_p1;
  logic [31:0]     busy_p1;

  assign valid = {bus.io_req2_valid, bus.io_req1_valid, bus.io_req0_valid};

  // Grant selection; stall and reset both force every ready low.
  always_comb begin
    grant = '0;
    if (reset && !bus.io_stall) grant = rr_pick(valid, last_p1);
  end

  assign gidx = grant_idx(grant);
  assign xfer = |grant;

  assign bus.io_req0_ready = grant[0];
  assign bus.io_req1_ready = grant[1];
  assign bus.io_req2_ready = grant[2];

  // Mux the granted requester's payload into the write stage.
  always_comb begin
    gaddr = bus.io_req0_addr;
    gdata = bus.io_req0_data;
    case (gidx)
      2'd1: begin
        gaddr = bus.io_req1_addr;
        gdata = bus.io_req1_data;
      end
      2'd2: begin
        gaddr = bus.io_req2_addr;
        gdata = bus.io_req2_data;
      end
      default: ;
    endcase
  end

  // Scoreboard update: a new issue (younger producer) overrides a same-cycle clear.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (xfer) clr_mask[gaddr] = 1'b1;
    if (bus.io_issue_valid) set_mask[bus.io_issue_rd] = 1'b1;
    busy_next    = (busy_p1 & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  // Arbitration pointer advances only on an actual transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_p1 <= 2'd2;
    else if (xfer) last_p1 <= gidx;
  end

  // Write stage: one-cycle write enable per transfer; x0 writes are swallowed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid_p1 <= 1'b0;
      wb_addr_p1  <= '0;
      wb_data_p1  <= '0;
    end else begin
      wb_valid_p1 <= xfer && (gaddr != 5'd0);
      if (xfer) begin
        wb_addr_p1 <= gaddr;
        wb_data_p1 <= gdata;
      end
    end
  end

  // Pending-write scoreboard, cleared on the same edge that loads the write stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_p1 <= '0;
    else busy_p1 <= busy_next;
  end

  assign bus.io_wb_valid     = wb_valid_p1;
  assign bus.io_wb_dest_addr = wb_addr_p1;
  assign bus.io_wb_dest_data = wb_data_p1;
  assign bus.io_busy         = busy_p1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a queue of expected write-stage results.
module tb_wb_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  wb_arbiter_if #(.XLEN(64)) bus ();

  wb_arbiter #(.NREQ(3), .XLEN(64)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        v;
    logic [4:0]  a;
    logic [63:0] d;
  } wb_t;

  wb_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
    case (i)
      0: begin bus.io_req0_valid = v; bus.io_req0_addr = a; bus.io_req0_data = d; end
      1: begin bus.io_req1_valid = v; bus.io_req1_addr = a; bus.io_req1_data = d; end
      default: begin bus.io_req2_valid = v; bus.io_req2_addr = a; bus.io_req2_data = d; end
    endcase
  endtask

  // One clock cycle: check grant mid-cycle, queue the expected write, check it after the edge.
  task automatic tick(input logic [2:0] exp_rdy, input logic [31:0] busy_after, input string tag);
    wb_t        e;
    logic [2:0] rdy;
    @(negedge clock);
    rdy = {bus.io_req2_ready, bus.io_req1_ready, bus.io_req0_ready};
    chk({tag, " ready"}, 64'(rdy), 64'(exp_rdy));
    chk({tag, " busy_pre"}, 64'(bus.io_busy), 64'(exp_busy));
    e = '0;
    if (exp_rdy[0]) begin e.a = bus.io_req0_addr; e.d = bus.io_req0_data; end
    if (exp_rdy[1]) begin e.a = bus.io_req1_addr; e.d = bus.io_req1_data; end
    if (exp_rdy[2]) begin e.a = bus.io_req2_addr; e.d = bus.io_req2_data; end
    e.v = (exp_rdy != 3'b000) && (e.a != 5'd0);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk({tag, " wb_valid"}, 64'(bus.io_wb_valid), 64'(e.v));
    if (e.v) begin
      chk({tag, " wb_addr"}, 64'(bus.io_wb_dest_addr), 64'(e.a));
      chk({tag, " wb_data"}, bus.io_wb_dest_data, e.d);
    end
    exp_busy = busy_after;
    chk({tag, " busy_post"}, 64'(bus.io_busy), 64'(exp_busy));
  endtask

  initial begin
    reset = 1'b0;
    exp_busy = '0;
    bus.io_stall = 1'b0;
    bus.io_issue_valid = 1'b0;
    bus.io_issue_rd = '0;
    drive_req(0, 1'b1, 5'd1, 64'h100);
    drive_req(1, 1'b1, 5'd2, 64'h200);
    drive_req(2, 1'b1, 5'd3, 64'h300);

    // Reset state with requests already pending
    #2;
    chk("rst ready", 64'({bus.io_req2_ready, bus.io_req1_ready, bus.io_req0_ready}), 64'd0);
    chk("rst wb_valid", 64'(bus.io_wb_valid), 64'd0);
    chk("rst wb_addr", 64'(bus.io_wb_dest_addr), 64'd0);
    chk("rst wb_data", bus.io_wb_dest_data, 64'd0);
    chk("rst busy", 64'(bus.io_busy), 64'd0);
    @(posedge clock);
    #1;
    chk("rst hold wb_valid", 64'(bus.io_wb_valid), 64'd0);
    reset = 1'b1;

    // All three continuously valid: 0,1,2,0,1,2
    tick(3'b001, 32'h0, "rr0");
    tick(3'b010, 32'h0, "rr1");
    tick(3'b100, 32'h0, "rr2");
    tick(3'b001, 32'h0, "rr3");
    tick(3'b010, 32'h0, "rr4");
    tick(3'b100, 32'h0, "rr5");
    drive_req(0, 1'b0, 5'd0, 64'h0);
    drive_req(1, 1'b0, 5'd0, 64'h0);
    drive_req(2, 1'b0, 5'd0, 64'h0);
    tick(3'b000, 32'h0, "idle");

    // Lone lsu write
    drive_req(1, 1'b1, 5'd5, 64'hDEAD_BEEF);
    tick(3'b010, 32'h0, "lsu");
    drive_req(1, 1'b0, 5'd0, 64'h0);
    tick(3'b000, 32'h0, "lsu after");

    // Issue rd=7, mdu writes back three cycles later
    bus.io_issue_valid = 1'b1;
    bus.io_issue_rd = 5'd7;
    tick(3'b000, 32'h80, "iss7");
    bus.io_issue_valid = 1'b0;
    tick(3'b000, 32'h80, "wait7a");
    tick(3'b000, 32'h80, "wait7b");
    drive_req(2, 1'b1, 5'd7, 64'h77);
    tick(3'b100, 32'h0, "wb7");
    drive_req(2, 1'b0, 5'd0, 64'h0);

    // Same-cycle issue and writeback of rd=9: set wins
    bus.io_issue_valid = 1'b1;
    bus.io_issue_rd = 5'd9;
    tick(3'b000, 32'h200, "iss9");
    drive_req(0, 1'b1, 5'd9, 64'h99);
    tick(3'b001, 32'h200, "iss9 wb9");
    bus.io_issue_valid = 1'b0;
    drive_req(0, 1'b0, 5'd0, 64'h0);

    // x0 write consumes the grant without enabling the write
    drive_req(2, 1'b1, 5'd13, 64'hD);
    tick(3'b100, 32'h200, "mdu13");
    drive_req(2, 1'b0, 5'd0, 64'h0);
    drive_req(0, 1'b1, 5'd0, 64'h1234);
    tick(3'b001, 32'h200, "x0");
    drive_req(0, 1'b1, 5'd10, 64'hA0);
    drive_req(1, 1'b1, 5'd11, 64'hB0);
    drive_req(2, 1'b1, 5'd12, 64'hC0);
    tick(3'b010, 32'h200, "after x0");

    // Stall two cycles, then resume after pre-stall pointer (last=1)
    bus.io_stall = 1'b1;
    tick(3'b000, 32'h200, "stall0");
    tick(3'b000, 32'h200, "stall1");
    bus.io_stall = 1'b0;
    tick(3'b100, 32'h200, "resume0");
    tick(3'b001, 32'h200, "resume1");

    // Asynchronous reset with a write in the write stage
    drive_req(0, 1'b0, 5'd0, 64'h0);
    drive_req(1, 1'b0, 5'd0, 64'h0);
    drive_req(2, 1'b0, 5'd0, 64'h0);
    bus.io_issue_valid = 1'b1;
    bus.io_issue_rd = 5'd20;
    tick(3'b000, 32'h0010_0200, "iss20");
    bus.io_issue_valid = 1'b0;
    drive_req(1, 1'b1, 5'd21, 64'hABC);
    tick(3'b010, 32'h0010_0200, "pre async");
    #1;
    reset = 1'b0;
    #1;
    chk("async wb_valid", 64'(bus.io_wb_valid), 64'd0);
    chk("async wb_addr", 64'(bus.io_wb_dest_addr), 64'd0);
    chk("async wb_data", bus.io_wb_dest_data, 64'd0);
    chk("async busy", 64'(bus.io_busy), 64'd0);
    chk("async ready", 64'({bus.io_req2_ready, bus.io_req1_ready, bus.io_req0_ready}), 64'd0);
    exp_busy = '0;
    @(negedge clock);
    reset = 1'b1;
    drive_req(1, 1'b0, 5'd0, 64'h0);
    tick(3'b000, 32'h0, "post async");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the commit stage's single general-purpose register write port between three writeback requesters: execute unit, load/store unit and multiply/divide unit. Uses a round-robin arbiter with a registered write stage. Keeps a 32-entry pending-write scoreboard so the issue stage can hold instructions whose source registers still await writeback. Sits between the execution units and the commit stage's `io_normal_wb_*` inputs.

## Interface
Parameters:
- `NREQ`, 3, number of requesters; fixed at 3, index 0 = exu, 1 = lsu, 2 = mdu.
- `XLEN`, 64, data width.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- `io_req{i}_valid`  in  1  requester i (i = 0..2) has a writeback pending.
- `io_req{i}_addr`  in  5  destination register of requester i.
- `io_req{i}_data`  in  XLEN  writeback data of requester i.
- `io_req{i}_ready`  out  1  grant; transfer occurs in any cycle where valid & ready.
- `io_stall`  in  1  commit stage cannot accept a write this cycle.
- `io_issue_valid`  in  1  an instruction with a register destination is issued this cycle.
- `io_issue_rd`  in  5  its destination register.
- `io_wb_valid`  out  1  register-file write enable (to commit `io_normal_wb_valid`).
- `io_wb_dest_addr`  out  5  write address.
- `io_wb_dest_data`  out  XLEN  write data.
- `io_busy`  out  32  bit r = 1 while register r has an issued, not yet written-back producer.

## Operation
- Requester-side contract: once `valid` is high, it is held, with `addr`/`data` stable, until the transfer.
- Arbitration:
  - Combinational and round-robin over the requesters with `valid` high.
  - The 2-bit pointer `last` records the most recently granted index.
  - Search order is (last+1)%3, (last+2)%3, last.
  - At most one `ready` is high per cycle.
- `io_stall`=1 forces every `ready` to 0.
- Pointer update: `last` is updated to the granted index only in cycles with a transfer.
- Write register: on a transfer from requester g, the next edge loads `io_wb_dest_addr`←addr_g and `io_wb_dest_data`←data_g.
  - `io_wb_valid` is set to 1, except when addr_g = 0.
  - An x0 write is accepted and consumes the grant (pointer advances), but `io_wb_valid` is 0.
  - No transfer → next edge sets `io_wb_valid`=0; addr and data hold their previous values.
- Scoreboard, per register r ≠ 0, applied at each edge:
  - Set when `io_issue_valid` & `io_issue_rd`=r.
  - Clear when a transfer with addr=r occurs this cycle.
  - Simultaneous set and clear of the same r: set wins, because the new producer is younger.
  - `io_busy[0]` is always 0; issue to rd=0 is ignored.
- The scoreboard does not count producers: one busy bit per register. The issue stage does not issue a second writer to a busy rd. Behaviour if it does: the first writeback clears the bit.
- There is no flush input; the pipeline drains outstanding requests before any redirect.

## Timing
- Grant latency: 0 cycles; `ready` is valid in the same cycle as `valid`.
- Write latency: transfer in cycle T → `io_wb_valid`/addr/data visible in T+1, for exactly one cycle per transfer.
- Busy-clear timing: the busy bit clears at the same edge that loads the write register. `io_busy[r]` falls in T+1, concurrently with `io_wb_valid`. Consumers reading in T+1 receive the data via the commit stage's same-cycle bypass.
- Throughput: one write per cycle.
- Fairness: a continuously valid requester is granted within 3 non-stalled cycles.
- Reset values, asynchronous:
  - `io_wb_valid`=0, `io_wb_dest_addr`=0, `io_wb_dest_data`=0.
  - `io_busy`=0.
  - `last`=2, so requester 0 has first priority after reset.
  - All `ready` outputs are 0 while `reset`=0.
- Reset asserted mid-operation: the pending write is discarded, `io_wb_valid` drops immediately, and all busy bits clear.
- Stall: `io_stall` sampled high in cycle T → no transfer in T, `io_wb_valid`=0 in T+1, pointer unchanged.

## Test plan
- Reset release, all three requesters valid continuously:
  - Grants go 0,1,2,0,1,2.
  - `io_wb_valid`=1 every cycle from the second cycle.
  - `io_wb_dest_addr` follows each requester's addr, one cycle late.
- Only req1 valid (addr=5, data=0xDEAD_BEEF):
  - `ready1`=1 in cycle T.
  - In T+1: `io_wb_valid`=1, addr=5, data=0xDEADBEEF.
  - In T+2: `io_wb_valid`=0.
- Issue rd=7 then req2 writes addr=7 three cycles later:
  - `io_busy[7]`=1 from the edge after issue.
  - `io_busy[7]` falls in the same cycle `io_wb_valid`=1 with addr=7.
- Same cycle: issue rd=9 and transfer with addr=9 (old producer) → `io_busy[9]` remains 1 after the edge.
- req0 valid with addr=0, data=0x1234:
  - `ready0`=1.
  - Next cycle `io_wb_valid`=0.
  - Next grant with all valid goes to req1.
- All valid and `io_stall`=1 for 2 cycles:
  - All `ready`=0.
  - `io_wb_valid`=0 for 2 cycles.
  - After release, grant resumes at the index following the pre-stall `last`.
- Additional: `reset` pulsed low during a pending transfer → outputs and `io_busy` zero immediately, without waiting for a clock edge.
